// File: rtl/ec_pkg.sv
// ec_pkg: shared mode encodings, sequencer states and helpers for the EC scalar multiplier
package ec_pkg;

    localparam logic EC_MODE_DA     = 1'b0;
    localparam logic EC_MODE_LADDER = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DBL,
        ST_ADD,
        ST_LADD,
        ST_LDBL,
        ST_DONE
    } ec_state_e;

    function automatic logic ec_is_op(ec_state_e s);
        return s inside {ST_DBL, ST_ADD, ST_LADD, ST_LDBL};
    endfunction

endpackage

// File: rtl/ec_scalar_mul_if.sv
// ec_scalar_mul_if: group-operation request/ack port between the multiplier and an add/double engine
interface ec_scalar_mul_if #(
    parameter int WIDTH = 192
) ();

    logic             op_req;
    logic             op_dbl;
    logic [WIDTH-1:0] op_x1;
    logic [WIDTH-1:0] op_y1;
    logic [WIDTH-1:0] op_x2;
    logic [WIDTH-1:0] op_y2;
    logic             op_inf1;
    logic             op_inf2;
    logic             op_ack;
    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic             op_inf;

    modport master (
        output op_req, op_dbl, op_x1, op_y1, op_x2, op_y2, op_inf1, op_inf2,
        input  op_ack, op_x, op_y, op_inf
    );

    modport slave (
        input  op_req, op_dbl, op_x1, op_y1, op_x2, op_y2, op_inf1, op_inf2,
        output op_ack, op_x, op_y, op_inf
    );

endinterface

// File: rtl/ec_point_reg.sv
// ec_point_reg: point register {x, y, inf} with clear-to-infinity and load
module ec_point_reg #(
    parameter int WIDTH = 192
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [2*WIDTH:0] i_d,
    output logic [2*WIDTH:0] o_q
);

    logic [2*WIDTH:0] r_q;

    // The infinity flag is the LSB, so clear leaves coordinates zero and flags infinity
    always_ff @(posedge i_clk) begin
        if (i_rst) r_q <= '0;
        else if (i_clr) r_q <= {{(2*WIDTH){1'b0}}, 1'b1};
        else if (i_load) r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/ec_scalar_mul.sv
// ec_scalar_mul: Q = k*P via double-and-add or Montgomery ladder over an external group-op engine
module ec_scalar_mul
    import ec_pkg::*;
#(
    parameter int WIDTH = 192,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_k,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result_x,
    output logic [WIDTH-1:0] o_result_y,
    output logic             o_inf,
    ec_scalar_mul_if.master  op
);

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic             inf;
    } point_t;

    ec_state_e        r_state;
    logic             r_mode, r_req, r_dbl, r_busy, r_done;
    logic [WIDTH-1:0] r_k, r_x, r_y;
    logic [CNT_W-1:0] r_idx;
    point_t           r_op1, r_op2, r_res;
    point_t           w_p, w_res, w_acc, w_r0, w_r1, w_acc_d, w_r1_d, w_op1, w_op2, w_fin;
    logic             w_start, w_ack, w_bit, w_last, w_acc_ld, w_r0_ld, w_r1_ld;

    // Decode the current step into point-register loads, next operands and completion
    always_comb begin
        w_start  = (r_state == ST_IDLE) && i_start;
        w_ack    = r_req && op.op_ack;
        w_bit    = r_k[r_idx];
        w_p      = point_t'{x: r_x, y: r_y, inf: 1'b0};
        w_res    = point_t'{x: op.op_x, y: op.op_y, inf: op.op_inf};
        w_acc_ld = (r_state == ST_SCAN && w_bit) || ((r_state == ST_DBL || r_state == ST_ADD) && w_ack);
        w_acc_d  = (r_state == ST_SCAN) ? w_p : w_res;
        w_r0_ld  = w_ack && ((r_state == ST_LADD && w_bit) || (r_state == ST_LDBL && !w_bit));
        w_r1_ld  = w_start || (w_ack && ((r_state == ST_LADD && !w_bit) || (r_state == ST_LDBL && w_bit)));
        w_r1_d   = w_start ? point_t'{x: i_x, y: i_y, inf: 1'b0} : w_res;
        w_fin    = (r_mode == EC_MODE_LADDER) ? (w_r0_ld ? w_res : w_r0) : (w_acc_ld ? w_acc_d : w_acc);
        w_last   = (r_idx == '0) && (r_state == ST_SCAN || (w_ack && (r_state == ST_ADD
                   || r_state == ST_LDBL || (r_state == ST_DBL && !w_bit))));
        w_op1    = (r_state == ST_DBL || r_state == ST_ADD) ? w_acc
                 : (r_state == ST_LADD || (r_state == ST_LDBL && !w_bit)) ? w_r0
                 : (r_state == ST_LDBL) ? w_r1 : '0;
        w_op2    = (r_state == ST_ADD) ? w_p : (r_state == ST_LADD) ? w_r1 : '0;
    end

    ec_point_reg #(.WIDTH(WIDTH)) u_acc (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_start), .i_load(w_acc_ld), .i_d(w_acc_d), .o_q(w_acc)
    );

    ec_point_reg #(.WIDTH(WIDTH)) u_r0 (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_start), .i_load(w_r0_ld), .i_d(w_res), .o_q(w_r0)
    );

    ec_point_reg #(.WIDTH(WIDTH)) u_r1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(1'b0), .i_load(w_r1_ld), .i_d(w_r1_d), .o_q(w_r1)
    );

    // Sequencer: operands are captured when req rises so they stay stable until ack
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_mode  <= 1'b0;
            r_k     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_idx   <= '0;
            r_req   <= 1'b0;
            r_dbl   <= 1'b0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_res   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_ack) r_req <= 1'b0;
            else if (ec_is_op(r_state) && !r_req) begin
                r_req <= 1'b1;
                r_dbl <= (r_state == ST_DBL) || (r_state == ST_LDBL);
                r_op1 <= w_op1;
                r_op2 <= w_op2;
            end
            if (w_last) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
                r_res   <= w_fin;
            end else begin
                case (r_state)
                    ST_IDLE: if (i_start) begin
                        r_state <= (i_mode == EC_MODE_LADDER) ? ST_LADD : ST_SCAN;
                        r_mode  <= i_mode;
                        r_k     <= i_k;
                        r_x     <= i_x;
                        r_y     <= i_y;
                        r_idx   <= CNT_W'(WIDTH - 1);
                        r_busy  <= 1'b1;
                    end
                    ST_SCAN: begin
                        r_idx <= r_idx - 1'b1;
                        if (w_bit) r_state <= ST_DBL;
                    end
                    ST_DBL: if (w_ack) begin
                        if (w_bit) r_state <= ST_ADD;
                        else r_idx <= r_idx - 1'b1;
                    end
                    ST_ADD: if (w_ack) begin
                        r_state <= ST_DBL;
                        r_idx   <= r_idx - 1'b1;
                    end
                    ST_LADD: if (w_ack) r_state <= ST_LDBL;
                    ST_LDBL: if (w_ack) begin
                        r_state <= ST_LADD;
                        r_idx   <= r_idx - 1'b1;
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_result_x = r_res.x;
    assign o_result_y = r_res.y;
    assign o_inf      = r_res.inf;
    assign op.op_req  = r_req;
    assign op.op_dbl  = r_dbl;
    assign op.op_x1   = r_op1.x;
    assign op.op_y1   = r_op1.y;
    assign op.op_inf1 = r_op1.inf;
    assign op.op_x2   = r_op2.x;
    assign op.op_y2   = r_op2.y;
    assign op.op_inf2 = r_op2.inf;

endmodule
